// File: rtl/delta_regress_gen_if.sv
// Shared feature-memory bus used by delta_regress_gen.
//   master : engine side; drives mem_addr / mem_wr_en / mem_wr_data and
//            receives mem_rd_data.
//   slave  : memory side; the mirror image.
// mem_rd_data is expected one cycle after the address that selects it.
interface delta_regress_gen_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wr_en;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport master (
    output mem_addr,
    output mem_wr_en,
    output mem_wr_data,
    input  mem_rd_data
  );

  modport slave (
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/delta_regress_gen.sv
// Regression delta engine: d[n][c] = sum_{k=1..W} k*(x[n+k][c] - x[n-k][c])
// over a cepstral matrix in the shared feature memory. Frame indices are
// clamped to [0, F-1], so every frame 0..F-1 gets a result.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle run request (only honoured when idle)
//   win_size             half-window W (0 -> 1, > MAX_WIN -> MAX_WIN)
//   frame_num, cep_num   matrix size F x C
//   src_off, dst_off     source / destination column bases (wrap mod 2^CEP_BITS)
//   mem                  memory bus (master side), address = {frame, column}
//   busy, done           run in progress / one-cycle completion pulse
module delta_regress_gen #(
  parameter int FRAME_BITS = 7,
  parameter int CEP_BITS   = 7,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WIN    = 3,
  parameter int FP_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            win_size,
  input  logic [FRAME_BITS-1:0] frame_num,
  input  logic [CEP_BITS-1:0]   cep_num,
  input  logic [CEP_BITS-1:0]   src_off,
  input  logic [CEP_BITS-1:0]   dst_off,
  delta_regress_gen_if.master   mem,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, RDP, RDM, CAPM, SUB, MUL, ACC, WR} state_t;

  localparam int                LAT_W    = (FP_LAT > 1) ? $clog2(FP_LAT) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(FP_LAT - 1);
  localparam logic [1:0]        WIN_MAX  = 2'(MAX_WIN);

  // Single-precision add, round-to-nearest-even, subnormals flushed to zero.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic              sa, sb;
    logic [7:0]        ea, eb, d;
    logic [26:0]       ma, mb;
    logic [27:0]       sum;
    logic              sticky;
    logic signed [9:0] er;
    logic [24:0]       rnd;
    logic [31:0]       res;
    res = 32'd0;
    if ((a[30:23] == 8'd0) && (b[30:23] == 8'd0)) begin
      res = {a[31] & b[31], 31'd0};
    end else if (b[30:23] == 8'd0) begin
      res = a;
    end else if (a[30:23] == 8'd0) begin
      res = b;
    end else begin
      // a side always carries the larger magnitude; 3 extra bits are guard/round/sticky
      if (b[30:0] > a[30:0]) begin
        sa = b[31]; ea = b[30:23]; ma = {1'b1, b[22:0], 3'b000};
        sb = a[31]; eb = a[30:23]; mb = {1'b1, a[22:0], 3'b000};
      end else begin
        sa = a[31]; ea = a[30:23]; ma = {1'b1, a[22:0], 3'b000};
        sb = b[31]; eb = b[30:23]; mb = {1'b1, b[22:0], 3'b000};
      end
      d      = ea - eb;
      sticky = 1'b0;
      if (d > 8'd26) begin
        sticky = 1'b1;
        mb     = 27'd0;
      end else begin
        for (int i = 0; i < 27; i++) begin
          sticky = sticky | (mb[i] & (i < int'(d)));
        end
        mb = mb >> d;
      end
      mb = {mb[26:1], mb[0] | sticky};
      er = $signed({2'b00, ea});
      if (sa == sb) begin
        sum = {1'b0, ma} + {1'b0, mb};
      end else begin
        sum = {1'b0, ma} - {1'b0, mb};
      end
      if (sum == 28'd0) begin
        res = 32'd0;
      end else begin
        if (sum[27]) begin
          sum = {1'b0, sum[27:2], sum[1] | sum[0]};
          er  = er + 10'sd1;
        end else begin
          for (int i = 0; i < 26; i++) begin
            er  = sum[26] ? er : (er - 10'sd1);
            sum = sum[26] ? sum : {sum[26:0], 1'b0};
          end
        end
        rnd = {1'b0, sum[26:3]} + {24'd0, sum[2] & (sum[3] | sum[1] | sum[0])};
        if (rnd[24]) begin
          rnd = rnd >> 1;
          er  = er + 10'sd1;
        end else begin
          rnd = rnd;
        end
        if (er <= 10'sd0) begin
          res = {sa, 31'd0};
        end else if (er >= 10'sd255) begin
          res = {sa, 8'hFF, 23'd0};
        end else begin
          res = {sa, er[7:0], rnd[22:0]};
        end
      end
    end
    return res;
  endfunction

  // Single-precision multiply, round-to-nearest-even, subnormals flushed to zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              sr, g, st;
    logic [47:0]       p;
    logic signed [9:0] er;
    logic [22:0]       mant;
    logic [24:0]       rnd;
    logic [31:0]       res;
    sr = a[31] ^ b[31];
    if ((a[30:23] == 8'd0) || (b[30:23] == 8'd0)) begin
      res = {sr, 31'd0};
    end else begin
      p  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      er = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
      if (p[47]) begin
        mant = p[46:24]; g = p[23]; st = |p[22:0];
        er   = er + 10'sd1;
      end else begin
        mant = p[45:23]; g = p[22]; st = |p[21:0];
      end
      rnd = {2'b01, mant} + {24'd0, g & (mant[0] | st)};
      if (rnd[24]) begin
        er = er + 10'sd1;
      end else begin
        er = er;
      end
      if (er <= 10'sd0) begin
        res = {sr, 31'd0};
      end else if (er >= 10'sd255) begin
        res = {sr, 8'hFF, 23'd0};
      end else begin
        res = {sr, er[7:0], rnd[24] ? 23'd0 : rnd[22:0]};
      end
    end
    return res;
  endfunction

  // Regression weight k as a float constant.
  function automatic logic [31:0] k_float(input logic [1:0] k);
    logic [31:0] r;
    case (k)
      2'd2:    r = 32'h4000_0000;
      2'd3:    r = 32'h4040_0000;
      default: r = 32'h3F80_0000;
    endcase
    return r;
  endfunction

  state_t                state, state_nxt;
  logic [1:0]            k, k_nxt, w_eff, w_nxt;
  logic [CEP_BITS-1:0]   c, c_nxt, c_cfg, cn_nxt, src_cfg, src_nxt, dst_cfg, dst_nxt;
  logic [FRAME_BITS-1:0] n, n_nxt, f_cfg, f_nxt;
  logic [LAT_W-1:0]      lat, lat_nxt;
  logic [31:0]           xp, xp_nxt, xm, xm_nxt, diff, diff_nxt, prod, prod_nxt, acc, acc_nxt;
  logic                  done_nxt;
  logic [31:0]           add_a, add_b, add_res, mul_res;
  logic [FRAME_BITS:0]   p_sum, f_max;
  logic [FRAME_BITS-1:0] p_idx, m_idx;
  logic [CEP_BITS-1:0]   src_col, dst_col;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [31:0]           wr_data_nxt;

  // One shared adder: SUB computes x_p + (-x_m), ACC computes acc + product.
  always_comb begin
    add_a   = (state == SUB) ? xp : acc;
    add_b   = (state == SUB) ? {~xm[31], xm[30:0]} : prod;
    add_res = fp_add(add_a, add_b);
    mul_res = fp_mul(diff, k_float(k));
  end

  // Next-state, loop counters and datapath updates.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    c_nxt     = c;
    n_nxt     = n;
    lat_nxt   = lat;
    w_nxt     = w_eff;
    f_nxt     = f_cfg;
    cn_nxt    = c_cfg;
    src_nxt   = src_cfg;
    dst_nxt   = dst_cfg;
    xp_nxt    = xp;
    xm_nxt    = xm;
    diff_nxt  = diff;
    prod_nxt  = prod;
    acc_nxt   = acc;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          w_nxt   = (win_size == 2'd0) ? 2'd1 : ((win_size > WIN_MAX) ? WIN_MAX : win_size);
          f_nxt   = frame_num;
          cn_nxt  = cep_num;
          src_nxt = src_off;
          dst_nxt = dst_off;
          if ((frame_num == {FRAME_BITS{1'b0}}) || (cep_num == {CEP_BITS{1'b0}})) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = RDP;
            k_nxt     = 2'd1;
            c_nxt     = {CEP_BITS{1'b0}};
            n_nxt     = {FRAME_BITS{1'b0}};
            acc_nxt   = 32'd0;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      RDP: state_nxt = RDM;
      RDM: begin
        xp_nxt    = mem.mem_rd_data;
        state_nxt = CAPM;
      end
      CAPM: begin
        xm_nxt    = mem.mem_rd_data;
        lat_nxt   = {LAT_W{1'b0}};
        state_nxt = SUB;
      end
      SUB: begin
        if (lat == LAT_LAST) begin
          diff_nxt  = add_res;
          lat_nxt   = {LAT_W{1'b0}};
          state_nxt = MUL;
        end else begin
          lat_nxt = lat + LAT_W'(1);
        end
      end
      MUL: begin
        if (lat == LAT_LAST) begin
          prod_nxt  = mul_res;
          lat_nxt   = {LAT_W{1'b0}};
          state_nxt = ACC;
        end else begin
          lat_nxt = lat + LAT_W'(1);
        end
      end
      ACC: begin
        if (lat == LAT_LAST) begin
          acc_nxt = add_res;
          lat_nxt = {LAT_W{1'b0}};
          if (k == w_eff) begin
            state_nxt = WR;
          end else begin
            k_nxt     = k + 2'd1;
            state_nxt = RDP;
          end
        end else begin
          lat_nxt = lat + LAT_W'(1);
        end
      end
      WR: begin
        k_nxt   = 2'd1;
        acc_nxt = 32'd0;
        if (c == (c_cfg - CEP_BITS'(1))) begin
          c_nxt = {CEP_BITS{1'b0}};
          if (n == (f_cfg - FRAME_BITS'(1))) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            n_nxt     = n + FRAME_BITS'(1);
            state_nxt = RDP;
          end
        end else begin
          c_nxt     = c + CEP_BITS'(1);
          state_nxt = RDP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address for the state being entered; clamping is one bit wider than a frame index.
  always_comb begin
    p_sum   = {1'b0, n_nxt} + (FRAME_BITS+1)'(k_nxt);
    f_max   = {1'b0, f_nxt - FRAME_BITS'(1)};
    p_idx   = (p_sum > f_max) ? f_max[FRAME_BITS-1:0] : p_sum[FRAME_BITS-1:0];
    m_idx   = ({1'b0, n_nxt} < (FRAME_BITS+1)'(k_nxt)) ? {FRAME_BITS{1'b0}}
                                                        : (n_nxt - FRAME_BITS'(k_nxt));
    src_col = src_nxt + c_nxt;
    dst_col = dst_nxt + c_nxt;
    case (state_nxt)
      RDP:     addr_nxt = {p_idx, src_col};
      RDM:     addr_nxt = {m_idx, src_col};
      WR:      addr_nxt = {n_nxt, dst_col};
      default: addr_nxt = mem.mem_addr;
    endcase
    wr_data_nxt = (state_nxt == WR) ? acc_nxt : mem.mem_wr_data;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath, configuration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k               <= 2'd1;
      c               <= {CEP_BITS{1'b0}};
      n               <= {FRAME_BITS{1'b0}};
      lat             <= {LAT_W{1'b0}};
      w_eff           <= 2'd1;
      f_cfg           <= {FRAME_BITS{1'b0}};
      c_cfg           <= {CEP_BITS{1'b0}};
      src_cfg         <= {CEP_BITS{1'b0}};
      dst_cfg         <= {CEP_BITS{1'b0}};
      xp              <= 32'd0;
      xm              <= 32'd0;
      diff            <= 32'd0;
      prod            <= 32'd0;
      acc             <= 32'd0;
      mem.mem_addr    <= {ADDR_WIDTH{1'b0}};
      mem.mem_wr_en   <= 1'b0;
      mem.mem_wr_data <= {DATA_WIDTH{1'b0}};
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      k               <= k_nxt;
      c               <= c_nxt;
      n               <= n_nxt;
      lat             <= lat_nxt;
      w_eff           <= w_nxt;
      f_cfg           <= f_nxt;
      c_cfg           <= cn_nxt;
      src_cfg         <= src_nxt;
      dst_cfg         <= dst_nxt;
      xp              <= xp_nxt;
      xm              <= xm_nxt;
      diff            <= diff_nxt;
      prod            <= prod_nxt;
      acc             <= acc_nxt;
      mem.mem_addr    <= addr_nxt;
      mem.mem_wr_en   <= (state_nxt == WR);
      mem.mem_wr_data <= wr_data_nxt;
      busy            <= (state_nxt != IDLE);
      done            <= done_nxt;
    end
  end

endmodule

// File: tb/tb_delta_regress_gen.sv
// Self-checking bench for delta_regress_gen: directed scenarios plus random
// runs, each compared write-by-write against a real-arithmetic model of the
// clamped regression formula.
module tb_delta_regress_gen;
  localparam int AW = 14;
  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] win_size = 2'd0;
  logic [6:0] frame_num = 7'd0;
  logic [6:0] cep_num = 7'd0;
  logic [6:0] src_off = 7'd0;
  logic [6:0] dst_off = 7'd0;
  logic       busy, done;

  always #5 clk = ~clk;

  delta_regress_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

  delta_regress_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .win_size  (win_size),
    .frame_num (frame_num),
    .cep_num   (cep_num),
    .src_off   (src_off),
    .dst_off   (dst_off),
    .mem       (mem_bus.master),
    .busy      (busy),
    .done      (done)
  );

  logic [31:0] mem [0:(1<<AW)-1];

  // read-only memory model: data one cycle after address
  always @(posedge clk) mem_bus.mem_rd_data <= mem[mem_bus.mem_addr];

  typedef struct { logic [13:0] addr; logic [31:0] data; } wr_t;
  wr_t         exp_q[$];
  logic [31:0] got_data[$];
  real         xv [0:15][0:15];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, busy_cnt = 0, done_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] to_f32(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // write/busy/done monitor, sampled on the falling edge
  always @(negedge clk) begin : monitor
    wr_t e;
    if (mem_bus.mem_wr_en) begin
      wr_cnt++;
      got_data.push_back(mem_bus.mem_wr_data);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("wr_addr", 32'(mem_bus.mem_addr), 32'(e.addr));
        check_eq("wr_data", mem_bus.mem_wr_data, e.data);
      end
    end
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  end

  // Load memory and build the expected write sequence for one run.
  task automatic prepare(input int win, input int f, input int c, input int src, input int dst);
    int  w, p, m;
    real d;
    w = (win == 0) ? 1 : win;
    for (int fi = 0; fi < f; fi++)
      for (int ci = 0; ci < c; ci++)
        mem[{7'(fi), 7'(src + ci)}] = to_f32(xv[fi][ci]);
    exp_q.delete();
    for (int ni = 0; ni < f; ni++) begin
      for (int ci = 0; ci < c; ci++) begin
        d = 0.0;
        for (int k = 1; k <= w; k++) begin
          p = (ni + k > f - 1) ? f - 1 : ni + k;
          m = (ni - k < 0) ? 0 : ni - k;
          d = d + k * (xv[p][ci] - xv[m][ci]);
        end
        exp_q.push_back('{addr: {7'(ni), 7'(dst + ci)}, data: to_f32(d)});
      end
    end
    wr_cnt = 0; busy_cnt = 0; done_cnt = 0;
    got_data.delete();
  endtask

  task automatic kick(input int win, input int f, input int c, input int src, input int dst);
    @(negedge clk);
    win_size = 2'(win); frame_num = 7'(f); cep_num = 7'(c);
    src_off = 7'(src); dst_off = 7'(dst);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_case(input string tag, input int win, input int f, input int c,
                          input int src, input int dst, input bit extra_start);
    int w, guard;
    w = (win == 0) ? 1 : win;
    prepare(win, f, c, src, dst);
    kick(win, f, c, src, dst);
    if (extra_start) begin
      repeat (3) @(negedge clk);
      frame_num = 7'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    guard = 0;
    while (done_cnt == 0 && guard < 20000) begin
      @(negedge clk); #1;
      guard++;
    end
    repeat (3) @(negedge clk);
    #1;
    check_eq({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(f * c));
    check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(f * c * (w * 6 + 1)));
    check_eq({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check_eq({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_lits(input string tag, input real l0, input real l1, input real l2,
                            input real l3, input real l4);
    real lit [5];
    lit = '{l0, l1, l2, l3, l4};
    for (int i = 0; i < 5; i++)
      check_eq(tag, (i < got_data.size()) ? got_data[i] : 32'hDEAD_BEEF, to_f32(lit[i]));
  endtask

  initial begin
    int guard, f, c, src, dst, win;
    for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) xv[i][j] = 0.0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_addr", 32'(mem_bus.mem_addr), 32'd0);
    check_eq("rst_wr_en", 32'(mem_bus.mem_wr_en), 32'd0);
    check_eq("rst_wr_data", mem_bus.mem_wr_data, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) xv[i][0] = real'(i);
    run_case("w2", 2, 5, 1, 5, 40, 1'b0);
    check_lits("w2_vals", 5.0, 8.0, 10.0, 8.0, 5.0);
    run_case("w1", 1, 5, 1, 5, 40, 1'b0);
    check_lits("w1_vals", 1.0, 2.0, 2.0, 2.0, 1.0);
    run_case("w0", 0, 5, 1, 5, 40, 1'b0);
    check_lits("w0_vals", 1.0, 2.0, 2.0, 2.0, 1.0);
    run_case("extra_start", 2, 5, 1, 5, 40, 1'b1);
    check_lits("extra_vals", 5.0, 8.0, 10.0, 8.0, 5.0);

    for (int i = 0; i < 3; i++) for (int j = 0; j < 13; j++) xv[i][j] = 1.5;
    run_case("const", 3, 3, 13, 0, 13, 1'b0);

    // empty run: done next cycle, no busy, no writes
    prepare(1, 0, 4, 0, 20);
    kick(1, 0, 4, 0, 20);
    #1;
    check_eq("f0_done", 32'(done), 32'd1);
    check_eq("f0_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    #1;
    check_eq("f0_wr_cnt", 32'(wr_cnt), 32'd0);
    check_eq("f0_done_cnt", 32'(done_cnt), 32'd1);

    // reset in the middle of a run
    for (int i = 0; i < 8; i++) for (int j = 0; j < 4; j++)
      xv[i][j] = real'(int'($urandom_range(0, 16)) - 8);
    prepare(3, 8, 4, 10, 60);
    kick(3, 8, 4, 10, 60);
    guard = 0;
    while (wr_cnt < 10 && guard < 5000) begin
      @(negedge clk); #1;
      guard++;
    end
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_addr", 32'(mem_bus.mem_addr), 32'd0);
    check_eq("mid_rst_wr_en", 32'(mem_bus.mem_wr_en), 32'd0);
    check_eq("mid_rst_wr_data", mem_bus.mem_wr_data, 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    #1;
    check_eq("mid_rst_wr_cnt", 32'(wr_cnt), 32'd10);
    check_eq("mid_rst_done_cnt", 32'(done_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_case("after_rst", 3, 8, 4, 10, 60, 1'b0);

    // random runs
    for (int r = 0; r < 8; r++) begin
      win = int'($urandom_range(0, 3));
      f   = int'($urandom_range(1, 10));
      c   = int'($urandom_range(1, 6));
      src = int'($urandom_range(0, 127));
      dst = (src + c + int'($urandom_range(0, 60))) % 128;
      for (int i = 0; i < f; i++) for (int j = 0; j < c; j++)
        xv[i][j] = real'(int'($urandom_range(0, 32)) - 16) / 2.0;
      run_case("rand", win, f, c, src, dst, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
